bus_xfer_ctrl: RTL and testbench
================================

BUS_XFER_CTRL -- requirements
Module: bus_xfer_ctrl

Interface
REQ-001 SHALL have parameter NREG, default 8: number of 12-bit latch registers controlled (2..8).
REQ-002 SHALL have parameter IW, default 3: register index width, IW = clog2(NREG).
REQ-003 SHALL have port CLK  in  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port RESET  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports req0, req1  in  1 each  transfer request from port 0 (CPU microcode) and port 1 (panel/DMA).
REQ-006 SHALL have ports src0, src1  in  IW each  source register index.
REQ-007 SHALL have ports dst0, dst1  in  IW each  destination register index.
REQ-008 SHALL have ports bsel0, bsel1  in  1 each  bus select: 0 = bus 1 (oe1), 1 = bus 2 (oe2).
REQ-009 SHALL have ports ack0, ack1  out  1 each  one-cycle completion pulse to the granted port.
REQ-010 SHALL have port err  out  1  qualifies ack; meaningful only when the checker is compiled in.
REQ-011 SHALL have port busy  out  1  high in every state except IDLE.
REQ-012 SHALL have ports oe1, oe2  out  NREG each  per-register output enables for bus 1 and bus 2.
REQ-013 SHALL have port hold  out  NREG  per-register hold; 1 = input stage frozen.
REQ-014 SHALL have port latch  out  NREG  per-register latch strobe; the register captures on the rising edge.

Function
REQ-015 SHALL implement states IDLE, DRIVE, LATCH and DONE.
REQ-016 IDLE: SHALL arbitrate when any req is high, register src/dst/bsel of the winner and go to DRIVE; otherwise stay.
REQ-017 Arbitration SHALL be round-robin: the port not granted last wins a tie; a lone requester wins immediately.
REQ-018 DRIVE: SHALL drive the selected oe bit of src one-hot and hold[dst]=0, with all latch bits 0.
REQ-019 LATCH: SHALL keep the DRIVE outputs and set latch[dst]=1 for exactly one cycle.
REQ-020 DONE: SHALL make latch 0, hold all 1s and oe1/oe2 all 0, pulse ack of the granted port, then go to IDLE.
REQ-021 Latency: a request sampled in IDLE at cycle n SHALL produce ack at cycle n+3; at most one transfer per 4 cycles.
REQ-022 Bus exclusivity: at most one bit across oe1|oe2 SHALL be set in any cycle, and never in IDLE or DONE.
REQ-023 Requesters SHALL hold req and fields stable until ack; dropping req mid-transfer SHALL NOT abort it, and ack still pulses.
REQ-024 A req still high in the cycle after its ack SHALL be treated as a new request.
REQ-025 Fields of the non-granted port SHALL be ignored until it is granted.

Reset
REQ-026 On RESET high at a clock edge: state SHALL become IDLE; oe1=oe2=0, latch=0, hold all 1s, ack0=ack1=err=busy=0.
REQ-027 The round-robin pointer SHALL reset so that port 0 wins the first tie.
REQ-028 RESET mid-transfer SHALL abandon the transfer without ack; outputs SHALL reach reset values in the same cycle and not glitch latch.

Configuration
REQ-029 Macro XFER_CHK_EN defined: a granted request with src==dst SHALL go IDLE->DONE with no oe, latch or hold activity, and ack pulses with err=1.
REQ-030 Macro XFER_CHK_EN undefined: err SHALL be tied 0, and src==dst SHALL run the normal 4-state sequence, so the register reloads its own value.

Structure
REQ-031 Package bus_xfer_pkg SHALL hold the state enum, the default NREG/IW constants and port index constants (PORT_CPU=0, PORT_AUX=1).
REQ-032 The two-way round-robin arbiter SHALL be sub-module rr_arb2 (inputs req[1:0]; outputs a one-hot grant and an update strobe).

Verification
REQ-033 Single req0, src=2, dst=5, bsel=0 -> oe1[2] high in DRIVE and LATCH; hold[5]=0; latch[5] high one cycle; ack0 at cycle +3.
REQ-034 req0 and req1 high together from reset -> port 0 acked first, port 1 acked 4 cycles later; repeat the tie -> port 1 wins.
REQ-035 Both reqs held continuously for 16 cycles -> grants alternate 0,1,0,1; ack every 4 cycles; oe1|oe2 never has more than one bit set.
REQ-036 RESET asserted during LATCH -> next cycle all oe=0, latch=0, hold=all 1s, no ack.
REQ-037 req1, src=dst=3, bsel=1 -> with XFER_CHK_EN: ack1+err after 1 cycle, no strobes; without it: full sequence, err=0.

Source files
------------

// File: rtl/bus_xfer_pkg.sv
// Shared types and constants for the bus transfer controller.
// Optional src==dst checker is enabled by defining XFER_CHK_EN.
package bus_xfer_pkg;

  localparam int NREG_DEF = 8;
  localparam int IW_DEF   = 3;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    LATCH = 2'd2,
    DONE  = 2'd3
  } xfer_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer advances only when a grant is taken.
module rr_arb2 (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant,
  output logic       update
);

  // Port granted most recently; resets to 1 so port 0 wins the first tie.
  logic last;

  always_comb begin
    grant = '0;
    if (req == 2'b11)
      grant = last ? 2'b01 : 2'b10;
    else
      grant = req;
  end

  assign update = en & (|req);

  always_ff @(posedge CLK) begin
    if (RESET)
      last <= 1'b1;
    else if (update)
      last <= grant[1];
  end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Register-to-register bus transfer sequencer with two arbitrated requesters.
// Define XFER_CHK_EN to reject src==dst transfers with an err-qualified ack.
module bus_xfer_ctrl
  import bus_xfer_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int IW   = IW_DEF
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            req0,
  input  logic            req1,
  input  logic [IW-1:0]   src0,
  input  logic [IW-1:0]   src1,
  input  logic [IW-1:0]   dst0,
  input  logic [IW-1:0]   dst1,
  input  logic            bsel0,
  input  logic            bsel1,
  output logic            ack0,
  output logic            ack1,
  output logic            err,
  output logic            busy,
  output logic [NREG-1:0] oe1,
  output logic [NREG-1:0] oe2,
  output logic [NREG-1:0] hold,
  output logic [NREG-1:0] latch
);

  xfer_state_t state;
  logic [1:0]    grant;
  logic          update;
  logic          sel_aux;
  logic          gport;
  logic [IW-1:0] s_src, s_dst, dst_q;
  logic          s_bsel;

  function automatic logic [NREG-1:0] onehot(input logic [IW-1:0] idx);
    return NREG'(1) << idx;
  endfunction

  rr_arb2 u_arb (
    .CLK    (CLK),
    .RESET  (RESET),
    .en     (state == IDLE),
    .req    ({req1, req0}),
    .grant  (grant),
    .update (update)
  );

  assign sel_aux = (grant == 2'b10);
  assign s_src   = sel_aux ? src1  : src0;
  assign s_dst   = sel_aux ? dst1  : dst0;
  assign s_bsel  = sel_aux ? bsel1 : bsel0;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      oe1   <= '0;
      oe2   <= '0;
      latch <= '0;
      hold  <= '1;
      ack0  <= 1'b0;
      ack1  <= 1'b0;
      err   <= 1'b0;
      busy  <= 1'b0;
      gport <= PORT_CPU;
      dst_q <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (update) begin
            gport <= sel_aux;
            dst_q <= s_dst;
            busy  <= 1'b1;
`ifdef XFER_CHK_EN
            // Self-transfer is rejected straight to DONE without touching the bus.
            if (s_src == s_dst) begin
              state <= DONE;
              ack0  <= ~sel_aux;
              ack1  <= sel_aux;
              err   <= 1'b1;
            end else
`endif
            begin
              state <= DRIVE;
              if (s_bsel)
                oe2 <= onehot(s_src);
              else
                oe1 <= onehot(s_src);
              hold <= ~onehot(s_dst);
            end
          end
        end
        DRIVE: begin
          state <= LATCH;
          latch <= onehot(dst_q);
        end
        LATCH: begin
          state <= DONE;
          latch <= '0;
          hold  <= '1;
          oe1   <= '0;
          oe2   <= '0;
          ack0  <= (gport == PORT_CPU);
          ack1  <= (gport == PORT_AUX);
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Scoreboard bench for bus_xfer_ctrl: stimulus pushes expected acks/latch strobes,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_bus_xfer_ctrl;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       req0, req1;
  logic [2:0] src0, src1, dst0, dst1;
  logic       bsel0, bsel1;
  logic       ack0, ack1, err, busy;
  logic [7:0] oe1, oe2, hold, latch;

  int cyc = 0;
  int checks = 0;
  int passes = 0;

  typedef struct {int cyc; logic port; logic err;} ack_t;
  typedef struct {int cyc; logic [7:0] lat; logic [7:0] o1; logic [7:0] o2; logic [7:0] hld;} lat_t;
  ack_t ackq[$];
  lat_t latq[$];

  bus_xfer_ctrl #(.NREG(8), .IW(3)) dut (
    .CLK(CLK), .RESET(RESET),
    .req0(req0), .req1(req1),
    .src0(src0), .src1(src1),
    .dst0(dst0), .dst1(dst1),
    .bsel0(bsel0), .bsel1(bsel1),
    .ack0(ack0), .ack1(ack1), .err(err), .busy(busy),
    .oe1(oe1), .oe2(oe2), .hold(hold), .latch(latch)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Expected normal transfer for a request first sampled at the edge after cycle c.
  task automatic exp_xfer(input int c, input logic port, input logic [2:0] src,
                          input logic [2:0] dst, input logic bsel);
    lat_t l;
    ack_t a;
    l.cyc = c + 2;
    l.lat = 8'b1 << dst;
    l.o1  = bsel ? 8'h00 : (8'b1 << src);
    l.o2  = bsel ? (8'b1 << src) : 8'h00;
    l.hld = ~(8'b1 << dst);
    latq.push_back(l);
    a.cyc = c + 3; a.port = port; a.err = 1'b0;
    ackq.push_back(a);
  endtask

  task automatic chk_rst(input string tag);
    @(negedge CLK);
    chk({tag, "_oe1"},   oe1,   32'h0);
    chk({tag, "_oe2"},   oe2,   32'h0);
    chk({tag, "_latch"}, latch, 32'h0);
    chk({tag, "_hold"},  hold,  32'hFF);
    chk({tag, "_flags"}, {ack1, ack0, err, busy}, 32'h0);
  endtask

  always @(negedge CLK) begin
    chk("bus_excl", ($countones(oe1 | oe2) <= 1), 32'h1);
    if (ack0 === 1'b1 || ack1 === 1'b1) begin
      if (ackq.size() == 0) chk("unexp_ack", {ack1, ack0}, 32'h0);
      else begin
        ack_t a;
        a = ackq.pop_front();
        chk("ack_cyc",  cyc, a.cyc);
        chk("ack_port", {ack1, ack0}, a.port ? 32'h2 : 32'h1);
        chk("ack_err",  err, a.err);
      end
    end
    if (latch !== 8'h00) begin
      if (latq.size() == 0) chk("unexp_latch", latch, 32'h0);
      else begin
        lat_t l;
        l = latq.pop_front();
        chk("lat_cyc",  cyc,   l.cyc);
        chk("lat_vec",  latch, l.lat);
        chk("lat_oe1",  oe1,   l.o1);
        chk("lat_oe2",  oe2,   l.o2);
        chk("lat_hold", hold,  l.hld);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int c;
    RESET = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    src0 = '0; src1 = '0; dst0 = '0; dst1 = '0; bsel0 = 1'b0; bsel1 = 1'b0;
    step(2);
    chk_rst("reset");
    step(1);
    RESET = 1'b0;

    // Single CPU transfer: reg2 -> reg5 over bus 1.
    c = cyc;
    req0 = 1'b1; src0 = 3'd2; dst0 = 3'd5; bsel0 = 1'b0;
    exp_xfer(c, 1'b0, 3'd2, 3'd5, 1'b0);
    step(1);
    @(negedge CLK);
    chk("drive_oe1",   oe1,   32'h04);
    chk("drive_oe2",   oe2,   32'h00);
    chk("drive_hold",  hold,  32'hDF);
    chk("drive_latch", latch, 32'h00);
    chk("drive_busy",  busy,  32'h1);
    step(2);
    req0 = 1'b0;
    step(1);

    // Tie from reset: port 0 first, then port 1 wins the repeated tie.
    RESET = 1'b1;
    step(1);
    RESET = 1'b0;
    c = cyc;
    req0 = 1'b1; src0 = 3'd1; dst0 = 3'd0; bsel0 = 1'b1;
    req1 = 1'b1; src1 = 3'd4; dst1 = 3'd6; bsel1 = 1'b0;
    exp_xfer(c,     1'b0, 3'd1, 3'd0, 1'b1);
    exp_xfer(c + 4, 1'b1, 3'd4, 3'd6, 1'b0);
    step(7);
    req0 = 1'b0; req1 = 1'b0;
    step(1);

    // Continuous contention: grants alternate 0,1,0,1 every 4 cycles.
    c = cyc;
    req0 = 1'b1; src0 = 3'd7; dst0 = 3'd0; bsel0 = 1'b0;
    req1 = 1'b1; src1 = 3'd0; dst1 = 3'd7; bsel1 = 1'b1;
    for (int k = 0; k < 4; k++)
      if (k % 2 == 0) exp_xfer(c + 4 * k, 1'b0, 3'd7, 3'd0, 1'b0);
      else            exp_xfer(c + 4 * k, 1'b1, 3'd0, 3'd7, 1'b1);
    step(15);
    req0 = 1'b0; req1 = 1'b0;
    step(1);

    // Reset during LATCH abandons the transfer with no ack.
    c = cyc;
    req1 = 1'b1; src1 = 3'd1; dst1 = 3'd2; bsel1 = 1'b0;
    begin
      lat_t l;
      l.cyc = c + 2; l.lat = 8'h04; l.o1 = 8'h02; l.o2 = 8'h00; l.hld = 8'hFB;
      latq.push_back(l);
    end
    step(2);
    RESET = 1'b1;
    req1 = 1'b0;
    step(1);
    chk_rst("mid_rst");
    step(1);
    RESET = 1'b0;

    // Self-transfer reg3 -> reg3 from port 1 on bus 2.
    c = cyc;
    req1 = 1'b1; src1 = 3'd3; dst1 = 3'd3; bsel1 = 1'b1;
`ifdef XFER_CHK_EN
    begin
      ack_t a;
      a.cyc = c + 1; a.port = 1'b1; a.err = 1'b1;
      ackq.push_back(a);
    end
    step(1);
    @(negedge CLK);
    chk("self_oe",    {oe2, oe1}, 32'h0);
    chk("self_latch", latch,      32'h0);
    chk("self_hold",  hold,       32'hFF);
    step(1);
    req1 = 1'b0;
`else
    exp_xfer(c, 1'b1, 3'd3, 3'd3, 1'b1);
    step(3);
    req1 = 1'b0;
`endif
    step(3);

    chk("ackq_empty", ackq.size(), 32'h0);
    chk("latq_empty", latq.size(), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
